// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default geometry,
// internal index width and the FSM state encoding.
package regdump_pkg;

    localparam int REGDUMP_NUM_REGS = 32;
    localparam int REGDUMP_AW       = 5;
    localparam int REGDUMP_DW       = 32;
    // One extra bit so the index can hold NUM_REGS (checksum beat index)
    // and never wraps before the end-of-dump comparison.
    localparam int REGDUMP_IW       = REGDUMP_AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader.
//
// Handshake: the master raises out_valid together with out_data, out_idx and
// out_last and keeps all four stable until a rising clk edge at which
// out_valid && out_ready are both high; that edge transfers exactly one beat.
// out_ready may change freely and may stay low for any number of cycles.
interface regfile_dump_reader_if
    import regdump_pkg::*;
#(
    parameter int AW = REGDUMP_AW,
    parameter int DW = REGDUMP_DW
);
    logic [DW-1:0] out_data;
    logic [AW:0]   out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (output out_data, output out_idx, output out_valid,
                    output out_last, input out_ready);
    modport slave  (input out_data, input out_idx, input out_valid,
                    input out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on start, walks every register through the
// asynchronous read port (ra/rd), streams each word with its index, and
// holds the CPU frozen for the whole dump so the image is coherent.
// Optional build macro REGDUMP_CHECKSUM_EN appends one extra beat carrying
// the XOR of all register words (index NUM_REGS, marked last).
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = REGDUMP_NUM_REGS,
    parameter int AW       = REGDUMP_AW,
    parameter int DW       = REGDUMP_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [AW-1:0]         ra,
    input  logic [DW-1:0]         rd,
    output logic                  freeze,
    output logic                  busy,
    output logic                  done,
    output state_t                dbg_state,
    regfile_dump_reader_if.master stream
);

    localparam int            IW   = AW + 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    state_t        state;
    logic [IW-1:0] idx;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] acc;
`endif

    logic hs;

    // Beat transfer on this edge.
    assign hs = stream.out_valid && stream.out_ready;

    // The read port always follows the index; idx is 0 whenever idle.
    assign ra        = idx[AW-1:0];
    assign freeze    = busy;
    assign dbg_state = state;

    // Dump sequencer: index counter, output registers and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            idx              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            stream.out_data  <= '0;
            stream.out_idx   <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc              <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifdef REGDUMP_CHECKSUM_EN
                    acc <= '0;
`endif
                    if (start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Word is captured once here and never re-read while
                    // the consumer back-pressures.
                    stream.out_data  <= rd;
                    stream.out_idx   <= idx;
                    stream.out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    stream.out_last  <= 1'b0;
`else
                    stream.out_last  <= (idx == LAST);
`endif
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (hs) begin
                        stream.out_valid <= 1'b0;
                        stream.out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                        acc <= acc ^ stream.out_data;
`endif
                        if (idx == LAST) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // Checksum includes the beat accepted right now.
                            stream.out_data  <= acc ^ stream.out_data;
                            stream.out_idx   <= IW'(NUM_REGS);
                            stream.out_valid <= 1'b1;
                            stream.out_last  <= 1'b1;
                            state            <= ST_CKSUM;
`else
                            done  <= 1'b1;
                            state <= ST_DONE;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (hs) begin
                        stream.out_valid <= 1'b0;
                        stream.out_last  <= 1'b0;
                        done             <= 1'b1;
                        state            <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader: table of whole-dump runs with random
// back-pressure, plus hand-written back-pressure, restart, reset-abort and
// register-change sequences. Expected beats come from a snapshot of the
// register image taken when the dump starts.
module tb_regfile_dump_reader;
    import regdump_pkg::*;

    localparam int NR = REGDUMP_NUM_REGS;
    localparam int AW = REGDUMP_AW;
    localparam int DW = REGDUMP_DW;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NUM_BEATS = NR + CK;
    // start applied before edge 1; first word valid after edge 2; each beat
    // takes 2 edges; done is high during cycle 2*NR+1 (+1 with checksum),
    // so a consumer registers it on edge 66 for a plain 32-register dump.
    localparam int DONE_EDGE = 2 * NR + 1 + CK;
    localparam int BW        = 1 + (AW + 1) + DW;
    localparam int BUDGET    = 3000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          freeze, busy, done;
    state_t        dbg_state;
    logic [DW-1:0] regs [NR];

    regfile_dump_reader_if #(.AW(AW), .DW(DW)) sif ();

    assign rd = regs[ra];

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd),
        .freeze(freeze), .busy(busy), .done(done), .dbg_state(dbg_state),
        .stream(sif)
    );

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] cur_beat();
        return {sif.out_last, sif.out_idx, sif.out_data};
    endfunction

    // Expected stream: every register in order, then the XOR beat if enabled.
    task automatic build_expected();
        logic [DW-1:0] x;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            exp_q.push_back({(CK == 0 && i == NR - 1) ? 1'b1 : 1'b0, (AW + 1)'(i), regs[i]});
            x ^= regs[i];
        end
        if (CK == 1) exp_q.push_back({1'b1, (AW + 1)'(NR), x});
    endtask

    // kind 0: sparse image; 1: random; 2: regs[i]=i with x7=0x77.
    task automatic load_image(input int kind);
        for (int i = 0; i < NR; i++) begin
            case (kind)
                0:       regs[i] = '0;
                1:       regs[i] = $urandom;
                default: regs[i] = DW'(i);
            endcase
        end
        if (kind == 0) begin
            regs[1]  = 32'h11111111;
            regs[30] = 32'hDEADBEEF;
            regs[31] = 32'h00000031;
        end
        if (kind == 2) regs[7] = 32'h77;
        regs[0] = '0;
    endtask

    // ---------------- driver ----------------
    // One full dump. Negative option values disable that corner case.
    task automatic run_dump(input int ready_pct, input int stall_idx, input int stall_len,
                            input int start_at_beat, input int chg_idx,
                            input int rst_at_idx, input int exp_done_edge);
        int edges, beats, done_cnt, done_edge, first_valid, stall_cnt;
        bit freeze_ok, hold_pending, injected, changed, aborted, finished;
        logic [BW-1:0] prev, exp_b;
        edges = 0; beats = 0; done_cnt = 0; done_edge = 0; first_valid = 0;
        stall_cnt = 0; freeze_ok = 1; hold_pending = 0; injected = 0;
        changed = 0; aborted = 0; finished = 0; prev = '0;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        while (edges < BUDGET && !finished && !aborted) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_edge = edges;
            end
            if (done_cnt > 0 && !done) begin
                finished = 1;
                chk("busy_low_after_done", {busy, freeze}, 2'b00);
            end else begin
                if (!(freeze && busy)) freeze_ok = 0;
                if (sif.out_valid && first_valid == 0) first_valid = edges;
                if (hold_pending) chk("hold_stable", cur_beat(), prev);
                if (chg_idx >= 0 && !changed && sif.out_valid && sif.out_idx == (AW + 1)'(chg_idx)) begin
                    regs[chg_idx] = 32'h9;
                    changed = 1;
                end
                if (stall_idx >= 0 && sif.out_valid && sif.out_idx == (AW + 1)'(stall_idx)
                    && stall_cnt < stall_len) begin
                    sif.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    sif.out_ready = ($urandom_range(0, 99) < ready_pct);
                end
                if (start_at_beat >= 0 && !injected && sif.out_valid && beats == start_at_beat) begin
                    start = 1'b1;
                    injected = 1;
                end
                if (rst_at_idx >= 0 && sif.out_valid && sif.out_idx == (AW + 1)'(rst_at_idx)) begin
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_async_stream",
                        {sif.out_valid, sif.out_last, sif.out_idx, sif.out_data}, '0);
                    chk("rst_async_status", {done, busy, freeze, ra}, '0);
                    chk("rst_async_state", dbg_state, ST_IDLE);
                    aborted = 1;
                end else if (sif.out_valid && sif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", cur_beat(), '0);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("beat", cur_beat(), exp_b);
                    end
                    beats++;
                end
                hold_pending = sif.out_valid && !sif.out_ready;
                prev = cur_beat();
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            done_cnt = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || sif.out_valid) done_cnt++;
            end
            chk("no_output_after_abort", done_cnt, 0);
            exp_q.delete();
            return;
        end
        if (!finished) begin
            chk("timeout", edges, 0);
            return;
        end
        sif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("beat_count", beats, NUM_BEATS);
        chk("done_pulses", done_cnt, 1);
        chk("freeze_held", freeze_ok, 1);
        if (exp_done_edge > 0) begin
            chk("first_valid_latency", first_valid, 2);
            chk("done_edge", done_edge, exp_done_edge);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int ready_pct;
        int image_kind;
        int exp_done_edge;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{100, 0, DONE_EDGE};
        vecs[1] = '{100, 1, DONE_EDGE};
        vecs[2] = '{50,  1, -1};
        vecs[3] = '{25,  2, -1};

        sif.out_ready = 1'b0;
        load_image(0);
        repeat (3) @(negedge clk);
        chk("reset_stream", {sif.out_valid, sif.out_last, sif.out_idx, sif.out_data}, '0);
        chk("reset_status", {done, busy, freeze, ra}, '0);
        chk("reset_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            load_image(vecs[v].image_kind);
            run_dump(vecs[v].ready_pct, -1, 0, -1, -1, -1, vecs[v].exp_done_edge);
        end

        // Long stall on x7: word and index held, single transfer on release.
        load_image(2);
        run_dump(100, 7, 5, -1, -1, -1, -1);

        // Start pulse mid-dump is ignored: still one dump, one done.
        load_image(0);
        run_dump(100, -1, 0, 10, -1, -1, -1);

        // Asynchronous reset during beat 15, then a clean dump from idx 0.
        load_image(1);
        run_dump(100, -1, 0, -1, -1, 15, -1);
        load_image(1);
        run_dump(70, -1, 0, -1, -1, -1, -1);

        // x5 rewritten after its fetch while stalled: streamed value stays 5.
        load_image(2);
        run_dump(100, 5, 4, -1, 5, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
